// File: rtl/switch_conditioner.sv
// Clocked bounceless-switch front end: two-contact synchroniser, stability-count debounce FSM,
// edge pulses and press counter. Define SWITCH_CONDITIONER_ERR_EN to build illegal-contact detection.
module switch_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int CNT_W       = 8
) (
  input  logic             CLKIN,
  input  logic             RST_N,
  input  logic             NO,
  input  logic             NC,
  output logic             BQ,
  output logic             BQ_RISE,
  output logic             BQ_FALL,
  output logic [CNT_W-1:0] PRESS_CNT,
  output logic             ERR
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO,
    CHK_HI,
    IDLE_HI,
    CHK_LO
  } state_t;

  logic [SYNC_STAGES-1:0] no_sync_q;
  logic [SYNC_STAGES-1:0] nc_sync_q;
  logic                   no_s;
  logic                   nc_s;
  logic                   cand;

  state_t                 state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   bq_q, bq_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;

  // Rest position (released) is NO open / NC closed, so the chains reset to 1 / 0.
  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      no_sync_q <= '1;
      nc_sync_q <= '0;
    end else begin
      no_sync_q <= {no_sync_q[SYNC_STAGES-2:0], NO};
      nc_sync_q <= {nc_sync_q[SYNC_STAGES-2:0], NC};
    end
  end

  assign no_s = no_sync_q[SYNC_STAGES-1];
  assign nc_s = nc_sync_q[SYNC_STAGES-1];

  // In-transit and illegal decodes both hold the current level.
  always_comb begin
    cand = bq_q;
    case ({no_s, nc_s})
      2'b01:   cand = 1'b1;
      2'b10:   cand = 1'b0;
      default: cand = bq_q;
    endcase
  end

`ifdef SWITCH_CONDITIONER_ERR_EN
  logic err_q;
  logic illegal_pre;

  // Tapping the penultimate stage lands ERR on the same edge no_s takes the illegal value.
  assign illegal_pre = ~no_sync_q[SYNC_STAGES-2] & ~nc_sync_q[SYNC_STAGES-2];

  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | illegal_pre;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE_LO;
      db_cnt_q    <= '0;
      bq_q        <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      bq_q        <= bq_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    bq_d        = bq_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      IDLE_LO: begin
        if (cand) begin
          state_d  = CHK_HI;
          db_cnt_d = DB_W'(1);
        end
      end
      CHK_HI: begin
        if (!cand) begin
          state_d  = IDLE_LO;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE_HI;
          db_cnt_d    = '0;
          bq_d        = 1'b1;
          rise_d      = 1'b1;
          press_cnt_d = press_cnt_q + CNT_W'(1);
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      IDLE_HI: begin
        if (!cand) begin
          state_d  = CHK_LO;
          db_cnt_d = DB_W'(1);
        end
      end
      CHK_LO: begin
        if (cand) begin
          state_d  = IDLE_HI;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE_LO;
          db_cnt_d = '0;
          bq_d     = 1'b0;
          fall_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = IDLE_LO;
        db_cnt_d = '0;
      end
    endcase
  end

  assign BQ        = bq_q;
  assign BQ_RISE   = rise_q;
  assign BQ_FALL   = fall_q;
  assign PRESS_CNT = press_cnt_q;

endmodule
